// File: rtl/rob_commit_pkg.sv
// Shared constants, entry layout and helpers for the reorder buffer.
// Holds data/tag widths, ROB depth and the per-entry record type.
package rob_commit_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int REG_TAG_WIDTH = 5;
  localparam int ROB_TAG_WIDTH = 4;
  localparam int ROB_SIZE      = 16;

  localparam logic [DATA_WIDTH-1:0]    ZERO_DATA    = '0;
  localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [DATA_WIDTH-1:0]    data_t;
  typedef logic [REG_TAG_WIDTH-1:0] reg_t;
  typedef logic [ROB_TAG_WIDTH-1:0] tag_t;

  typedef struct packed {
    logic  busy;
    logic  ready;
    reg_t  dest;
    logic  is_branch;
    logic  pred_taken;
    logic  taken;
    data_t value;
    data_t target;
  } rob_entry_t;

  function automatic logic mispredict(
    input rob_entry_t e
  );
    return e.is_branch &&
           (e.taken != e.pred_taken);
  endfunction

endpackage

// File: rtl/rob_commit_if.sv
// Decode, CDB and commit bundle of the ROB.
// master: decode/CDB side driving in_*; slave: ROB driving out_*.
interface rob_commit_if;
  import rob_commit_pkg::*;

  logic  in_decode_ce;
  reg_t  in_decode_dest_reg;
  logic  in_decode_is_branch;
  logic  in_decode_pred_taken;
  tag_t  in_decode_query_tag1;
  tag_t  in_decode_query_tag2;
  tag_t  out_decode_alloc_tag;
  logic  out_decode_full;
  data_t out_decode_value1;
  data_t out_decode_value2;
  logic  out_decode_ready1;
  logic  out_decode_ready2;

  logic  in_cdb_valid;
  tag_t  in_cdb_rob_tag;
  data_t in_cdb_value;
  logic  in_cdb_taken;
  data_t in_cdb_target;

  reg_t  out_commit_reg;
  tag_t  out_commit_rob;
  data_t out_commit_value;
  logic  out_misbranch;
  data_t out_misbranch_pc;

  modport master (
    output in_decode_ce,
    output in_decode_dest_reg,
    output in_decode_is_branch,
    output in_decode_pred_taken,
    output in_decode_query_tag1,
    output in_decode_query_tag2,
    input  out_decode_alloc_tag,
    input  out_decode_full,
    input  out_decode_value1,
    input  out_decode_value2,
    input  out_decode_ready1,
    input  out_decode_ready2,
    output in_cdb_valid,
    output in_cdb_rob_tag,
    output in_cdb_value,
    output in_cdb_taken,
    output in_cdb_target,
    input  out_commit_reg,
    input  out_commit_rob,
    input  out_commit_value,
    input  out_misbranch,
    input  out_misbranch_pc
  );

  modport slave (
    input  in_decode_ce,
    input  in_decode_dest_reg,
    input  in_decode_is_branch,
    input  in_decode_pred_taken,
    input  in_decode_query_tag1,
    input  in_decode_query_tag2,
    output out_decode_alloc_tag,
    output out_decode_full,
    output out_decode_value1,
    output out_decode_value2,
    output out_decode_ready1,
    output out_decode_ready2,
    input  in_cdb_valid,
    input  in_cdb_rob_tag,
    input  in_cdb_value,
    input  in_cdb_taken,
    input  in_cdb_target,
    output out_commit_reg,
    output out_commit_rob,
    output out_commit_value,
    output out_misbranch,
    output out_misbranch_pc
  );

endinterface

// File: rtl/rob_commit_queue_ctrl.sv
// Head/tail/count pointers of the ROB circular queue with full flag.
// Ports: clk, rst, alloc/commit/flush strobes -> head, tail, full.
module rob_queue_ctrl
  import rob_commit_pkg::*;
#(
  parameter int SIZE  = ROB_SIZE,
  parameter int TAG_W = ROB_TAG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic             commit,
  input  logic             flush,
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail,
  output logic             full
);

  logic [TAG_W:0] count;

  assign full = (count == (TAG_W+1)'(SIZE));

  // Pointers wrap naturally since SIZE is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc)
        tail <= tail + 1'b1;
      if (commit)
        head <= head + 1'b1;
      unique case ({alloc, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: allocates tags, collects CDB results, commits in order.
// Ports: clk, rst, rdy, bus (rob_commit_if.slave). Option: ROB_CDB_BYPASS_EN.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int ROB_SIZE  = rob_commit_pkg::ROB_SIZE,
  parameter int ROB_TAG_W = ROB_TAG_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  rob_commit_if.slave  bus
);

  rob_entry_t ent [ROB_SIZE];

  logic [ROB_TAG_W-1:0] head;
  logic [ROB_TAG_W-1:0] tail;
  logic                 full;
  rob_entry_t           hd;
  logic                 do_alloc;
  logic                 do_commit;
  logic                 flush;
  logic                 cdb_hit;

  assign hd        = ent[head];
  assign do_commit = rdy && hd.busy && hd.ready;
  assign flush     = do_commit && mispredict(hd);
  assign do_alloc  = rdy && bus.in_decode_ce && !full;
  assign cdb_hit   = rdy && bus.in_cdb_valid &&
                     ent[bus.in_cdb_rob_tag].busy;

  rob_queue_ctrl #(
    .SIZE  (ROB_SIZE),
    .TAG_W (ROB_TAG_W)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .alloc  (do_alloc),
    .commit (do_commit),
    .flush  (flush),
    .head   (head),
    .tail   (tail),
    .full   (full)
  );

  assign bus.out_decode_full      = full;
  assign bus.out_decode_alloc_tag = tail;

  rob_entry_t q1;
  rob_entry_t q2;

  always_comb begin
    q1 = ent[bus.in_decode_query_tag1];
    q2 = ent[bus.in_decode_query_tag2];
    bus.out_decode_ready1 = q1.busy && q1.ready;
    bus.out_decode_value1 = q1.value;
    bus.out_decode_ready2 = q2.busy && q2.ready;
    bus.out_decode_value2 = q2.value;
`ifdef ROB_CDB_BYPASS_EN
    if (bus.in_cdb_valid && q1.busy &&
        bus.in_cdb_rob_tag == bus.in_decode_query_tag1) begin
      bus.out_decode_ready1 = TRUE;
      bus.out_decode_value1 = bus.in_cdb_value;
    end
    if (bus.in_cdb_valid && q2.busy &&
        bus.in_cdb_rob_tag == bus.in_decode_query_tag2) begin
      bus.out_decode_ready2 = TRUE;
      bus.out_decode_value2 = bus.in_cdb_value;
    end
`endif
  end

  // Order matters: commit clears after a same-cycle CDB write,
  // and allocation never hits a busy slot because full is checked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++)
        ent[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent[i].busy  <= FALSE;
        ent[i].ready <= FALSE;
      end
    end else begin
      if (cdb_hit) begin
        ent[bus.in_cdb_rob_tag].ready  <= TRUE;
        ent[bus.in_cdb_rob_tag].value  <= bus.in_cdb_value;
        ent[bus.in_cdb_rob_tag].taken  <= bus.in_cdb_taken;
        ent[bus.in_cdb_rob_tag].target <= bus.in_cdb_target;
      end
      if (do_commit) begin
        ent[head].busy  <= FALSE;
        ent[head].ready <= FALSE;
      end
      if (do_alloc) begin
        ent[tail].busy       <= TRUE;
        ent[tail].ready      <= FALSE;
        ent[tail].dest       <= bus.in_decode_dest_reg;
        ent[tail].is_branch  <= bus.in_decode_is_branch;
        ent[tail].pred_taken <= bus.in_decode_pred_taken;
      end
    end
  end

  reg_t  c_reg;
  tag_t  c_rob;
  data_t c_val;
  logic  mb;
  data_t mb_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_reg <= '0;
      c_rob <= ZERO_TAG_ROB;
      c_val <= ZERO_DATA;
      mb    <= FALSE;
      mb_pc <= ZERO_DATA;
    end else if (do_commit) begin
      c_reg <= hd.is_branch ? '0 : hd.dest;
      c_rob <= head;
      c_val <= hd.value;
      mb    <= flush;
      mb_pc <= flush ? hd.target : ZERO_DATA;
    end else begin
      c_reg <= '0;
      c_rob <= ZERO_TAG_ROB;
      c_val <= ZERO_DATA;
      mb    <= FALSE;
      mb_pc <= ZERO_DATA;
    end
  end

  assign bus.out_commit_reg   = c_reg;
  assign bus.out_commit_rob   = c_rob;
  assign bus.out_commit_value = c_val;
  assign bus.out_misbranch    = mb;
  assign bus.out_misbranch_pc = mb_pc;

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: vector table plus corner sequences.
// Commits are checked against a scoreboard queue by a negedge monitor.
module tb_rob_commit;
  import rob_commit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  always #5 clk = ~clk;

  rob_commit_if bus ();

  rob_commit dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  typedef struct {
    logic        ce;
    logic [4:0]  dest;
    logic        cv;
    logic [3:0]  ctag;
    logic [31:0] cval;
    logic [3:0]  q1;
    logic [3:0]  e_tag;
    logic        e_full;
    logic        e_rdy1;
    logic [31:0] e_val1;
    logic        push;
    logic [4:0]  pdest;
    logic [3:0]  ptag;
    logic [31:0] pval;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [3:0]  t;
    logic [31:0] v;
  } exp_t;

  exp_t sbq [$];
  vec_t vecs [13];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic push(input logic [4:0] r,
                      input logic [3:0] t,
                      input logic [31:0] v);
    exp_t e;
    e.r = r;
    e.t = t;
    e.v = v;
    sbq.push_back(e);
  endtask

  function automatic vec_t mk(
    input logic ce, input logic [4:0] dest,
    input logic cv, input logic [3:0] ctag,
    input logic [31:0] cval, input logic [3:0] q1,
    input logic [3:0] e_tag, input logic e_full,
    input logic e_rdy1, input logic [31:0] e_val1,
    input logic p, input logic [4:0] pd,
    input logic [3:0] pt, input logic [31:0] pv);
    vec_t x;
    x.ce = ce; x.dest = dest;
    x.cv = cv; x.ctag = ctag; x.cval = cval;
    x.q1 = q1; x.e_tag = e_tag; x.e_full = e_full;
    x.e_rdy1 = e_rdy1; x.e_val1 = e_val1;
    x.push = p; x.pdest = pd; x.ptag = pt; x.pval = pv;
    return x;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_commit_reg != 5'd0) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL commit_unexpected: got reg %0d rob %0d val %h, expected none",
                 bus.out_commit_reg, bus.out_commit_rob,
                 bus.out_commit_value);
      end else begin
        e = sbq.pop_front();
        chk("commit_reg", 32'(bus.out_commit_reg), 32'(e.r));
        chk("commit_rob", 32'(bus.out_commit_rob), 32'(e.t));
        chk("commit_value", bus.out_commit_value, e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1;
    bus.in_decode_ce = 1'b0;
    bus.in_decode_dest_reg = '0;
    bus.in_decode_is_branch = 1'b0;
    bus.in_decode_pred_taken = 1'b0;
    bus.in_decode_query_tag1 = '0;
    bus.in_decode_query_tag2 = '0;
    bus.in_cdb_valid = 1'b0;
    bus.in_cdb_rob_tag = '0;
    bus.in_cdb_value = '0;
    bus.in_cdb_taken = 1'b0;
    bus.in_cdb_target = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic alloc(input logic [4:0] d);
    bus.in_decode_ce = 1'b1;
    bus.in_decode_dest_reg = d;
  endtask

  task automatic cdb(input logic [3:0] t,
                     input logic [31:0] v);
    bus.in_cdb_valid = 1'b1;
    bus.in_cdb_rob_tag = t;
    bus.in_cdb_value = v;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_alloc_tag", 32'(bus.out_decode_alloc_tag), 0);
    chk("rst_full", 32'(bus.out_decode_full), 0);
    chk("rst_commit_reg", 32'(bus.out_commit_reg), 0);
    chk("rst_commit_value", bus.out_commit_value, 0);
    chk("rst_misbranch", 32'(bus.out_misbranch), 0);
    chk("rst_ready1", 32'(bus.out_decode_ready1), 0);

    vecs[0]  = mk(1,5, 0,0,0,        15, 0,0, 0,0,       0,0,0,0);
    vecs[1]  = mk(0,0, 1,0,32'h1234, 15, 1,0, 0,0,       0,0,0,0);
    vecs[2]  = mk(0,0, 0,0,0,         0, 1,0, 1,32'h1234, 1,5,0,32'h1234);
    vecs[3]  = mk(1,7, 0,0,0,        15, 1,0, 0,0,       0,0,0,0);
    vecs[4]  = mk(1,8, 0,0,0,        15, 2,0, 0,0,       0,0,0,0);
    vecs[5]  = mk(1,9, 0,0,0,        15, 3,0, 0,0,       0,0,0,0);
    vecs[6]  = mk(0,0, 1,3,32'h33,   15, 4,0, 0,0,       0,0,0,0);
    vecs[7]  = mk(0,0, 1,2,32'h22,    3, 4,0, 1,32'h33,  0,0,0,0);
    vecs[8]  = mk(0,0, 1,1,32'h11,   15, 4,0, 0,0,       0,0,0,0);
    vecs[9]  = mk(0,0, 0,0,0,         2, 4,0, 1,32'h22,  1,7,1,32'h11);
    vecs[10] = mk(0,0, 0,0,0,        15, 4,0, 0,0,       1,8,2,32'h22);
    vecs[11] = mk(0,0, 0,0,0,         3, 4,0, 1,32'h33,  1,9,3,32'h33);
    vecs[12] = mk(0,0, 0,0,0,         1, 4,0, 0,0,       0,0,0,0);

    for (int i = 0; i < 13; i++) begin
      idle();
      bus.in_decode_ce = vecs[i].ce;
      bus.in_decode_dest_reg = vecs[i].dest;
      bus.in_cdb_valid = vecs[i].cv;
      bus.in_cdb_rob_tag = vecs[i].ctag;
      bus.in_cdb_value = vecs[i].cval;
      bus.in_decode_query_tag1 = vecs[i].q1;
      #1;
      chk($sformatf("v%0d_alloc_tag", i),
          32'(bus.out_decode_alloc_tag), 32'(vecs[i].e_tag));
      chk($sformatf("v%0d_full", i),
          32'(bus.out_decode_full), 32'(vecs[i].e_full));
      chk($sformatf("v%0d_ready1", i),
          32'(bus.out_decode_ready1), 32'(vecs[i].e_rdy1));
      if (vecs[i].e_rdy1)
        chk($sformatf("v%0d_value1", i),
            bus.out_decode_value1, vecs[i].e_val1);
      if (vecs[i].push)
        push(vecs[i].pdest, vecs[i].ptag, vecs[i].pval);
      tick();
    end

    // Fill to full, refused allocations, wrap of tail.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(5'(i + 1));
      #1;
      chk($sformatf("fill_tag%0d", i),
          32'(bus.out_decode_alloc_tag), 32'(i));
      tick();
    end
    idle();
    #1;
    chk("fill_full", 32'(bus.out_decode_full), 1);
    chk("fill_tag_wrap", 32'(bus.out_decode_alloc_tag), 0);
    alloc(5'd30);
    tick();
    idle();
    #1;
    chk("ovf_full", 32'(bus.out_decode_full), 1);
    cdb(4'd0, 32'hA0);
    tick();
    idle();
    alloc(5'd20);
    #1;
    chk("full_commit_full", 32'(bus.out_decode_full), 1);
    push(5'd1, 4'd0, 32'hA0);
    tick();
    idle();
    #1;
    chk("after_commit_full", 32'(bus.out_decode_full), 0);
    chk("after_commit_tag", 32'(bus.out_decode_alloc_tag), 0);
    alloc(5'd21);
    tick();
    idle();
    #1;
    chk("wrap_full", 32'(bus.out_decode_full), 1);
    chk("wrap_tag", 32'(bus.out_decode_alloc_tag), 1);

    // Misprediction flush.
    do_reset();
    alloc(5'd3);
    bus.in_decode_is_branch = 1'b1;
    tick();
    idle();
    alloc(5'd4);
    tick();
    alloc(5'd5);
    tick();
    alloc(5'd6);
    cdb(4'd0, 32'h0);
    bus.in_cdb_taken = 1'b1;
    bus.in_cdb_target = 32'h100;
    tick();
    idle();
    alloc(5'd7);
    cdb(4'd1, 32'h77);
    tick();
    idle();
    bus.in_decode_query_tag1 = 4'd1;
    #1;
    chk("mb_pulse", 32'(bus.out_misbranch), 1);
    chk("mb_pc", bus.out_misbranch_pc, 32'h100);
    chk("mb_commit_reg", 32'(bus.out_commit_reg), 0);
    chk("mb_alloc_tag", 32'(bus.out_decode_alloc_tag), 0);
    chk("mb_full", 32'(bus.out_decode_full), 0);
    chk("mb_ready1", 32'(bus.out_decode_ready1), 0);
    tick();
    chk("mb_pulse_end", 32'(bus.out_misbranch), 0);
    chk("mb_pc_end", bus.out_misbranch_pc, 0);
    cdb(4'd1, 32'h99);
    tick();
    idle();
    tick();
    bus.in_decode_query_tag1 = 4'd1;
    #1;
    chk("mb_stale_cdb", 32'(bus.out_decode_ready1), 0);
    alloc(5'd12);
    #1;
    chk("mb_realloc_tag", 32'(bus.out_decode_alloc_tag), 0);
    tick();
    idle();
    cdb(4'd0, 32'hBE);
    tick();
    idle();
    push(5'd12, 4'd0, 32'hBE);
    tick();
    tick();

    // Same-cycle CDB visibility on operand query.
    do_reset();
    alloc(5'd10);
    tick();
    alloc(5'd11);
    tick();
    idle();
    cdb(4'd1, 32'h55);
    bus.in_decode_query_tag1 = 4'd1;
    bus.in_decode_query_tag2 = 4'd1;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("byp_ready1", 32'(bus.out_decode_ready1), 1);
    chk("byp_value1", bus.out_decode_value1, 32'h55);
    chk("byp_ready2", 32'(bus.out_decode_ready2), 1);
`else
    chk("nobyp_ready1", 32'(bus.out_decode_ready1), 0);
    chk("nobyp_ready2", 32'(bus.out_decode_ready2), 0);
`endif
    tick();
    idle();
    bus.in_decode_query_tag1 = 4'd1;
    bus.in_decode_query_tag2 = 4'd1;
    #1;
    chk("stored_ready1", 32'(bus.out_decode_ready1), 1);
    chk("stored_value1", bus.out_decode_value1, 32'h55);
    chk("stored_ready2", 32'(bus.out_decode_ready2), 1);
    cdb(4'd0, 32'h44);
    tick();
    idle();
    push(5'd10, 4'd0, 32'h44);
    tick();
    push(5'd11, 4'd1, 32'h55);
    tick();
    tick();

    // rdy freeze and asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      alloc(5'(i + 1));
      tick();
    end
    idle();
    #1;
    chk("frz_tag_pre", 32'(bus.out_decode_alloc_tag), 7);
    for (int i = 0; i < 3; i++) begin
      rdy = 1'b0;
      alloc(5'd9);
      cdb(4'd0, 32'h5A);
      #1;
      chk($sformatf("frz_tag%0d", i),
          32'(bus.out_decode_alloc_tag), 7);
      tick();
    end
    idle();
    bus.in_decode_query_tag1 = 4'd0;
    #1;
    chk("frz_tag_post", 32'(bus.out_decode_alloc_tag), 7);
    chk("frz_cdb_ignored", 32'(bus.out_decode_ready1), 0);
    cdb(4'd0, 32'h5A);
    tick();
    idle();
    cdb(4'd1, 32'h6B);
    push(5'd1, 4'd0, 32'h5A);
    tick();
    idle();
    rdy = 1'b0;
    tick();
    chk("frz_commit_reg", 32'(bus.out_commit_reg), 0);
    chk("frz_commit_value", bus.out_commit_value, 0);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_commit_reg", 32'(bus.out_commit_reg), 2);
    chk("pre_rst_commit_value", bus.out_commit_value, 32'h6B);
    rst = 1'b1;
    #1;
    chk("arst_commit_reg", 32'(bus.out_commit_reg), 0);
    chk("arst_commit_rob", 32'(bus.out_commit_rob), 0);
    chk("arst_commit_value", bus.out_commit_value, 0);
    chk("arst_full", 32'(bus.out_decode_full), 0);
    chk("arst_alloc_tag", 32'(bus.out_decode_alloc_tag), 0);
    chk("arst_ready1", 32'(bus.out_decode_ready1), 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("sb_empty", 32'(sbq.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer: allocates ROB tags to decode, collects results from the common data bus (CDB), and commits in program order.
- Commit output drives the architectural register file's commit port (reg, rob tag, value).
- Detects branch mispredictions at commit and broadcasts a one-cycle misbranch flush.
- Sits between decode/issue, the execution units (via CDB) and the register file.

Parameters:
- ROB_SIZE, 16, number of entries; power of two.
- ROB_TAG_W, 4, tag width; equals log2(ROB_SIZE).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- rdy  in  1  global enable; state frozen when low.
- in_decode_ce  in  1  allocate one entry this cycle.
- in_decode_dest_reg  in  5  destination architectural register; 0 means no write.
- in_decode_is_branch  in  1  entry is a conditional branch.
- in_decode_pred_taken  in  1  predicted direction.
- in_decode_query_tag1 / in_decode_query_tag2  in  ROB_TAG_W  operand lookups.
- out_decode_alloc_tag  out  ROB_TAG_W  tag the next allocation will receive (tail).
- out_decode_full  out  1  no free entry.
- out_decode_value1 / out_decode_value2  out  32  stored result for the queried tag.
- out_decode_ready1 / out_decode_ready2  out  1  queried entry busy and result valid.
- in_cdb_valid  in  1  result broadcast.
- in_cdb_rob_tag  in  ROB_TAG_W  producing entry.
- in_cdb_value  in  32  result value.
- in_cdb_taken  in  1  actual branch direction.
- in_cdb_target  in  32  correct next PC for the branch.
- out_commit_reg  out  5  committed destination; 0 = no commit.
- out_commit_rob  out  ROB_TAG_W  committed tag.
- out_commit_value  out  32  committed value.
- out_misbranch  out  1  flush pulse.
- out_misbranch_pc  out  32  redirect PC.

Behaviour:
- Circular queue with head, tail and count. Each entry holds busy, ready, dest_reg, is_branch, pred_taken, taken, value, target.
- Reset (async):
  - head, tail and count are 0.
  - All entries are not busy and not ready.
  - All registered outputs are 0.
- Full/empty flags:
  - out_decode_full = (count == ROB_SIZE); combinational, based on the pre-update count.
  - out_decode_alloc_tag = tail.
- Allocation: when rdy && in_decode_ce && !full, entry[tail] becomes busy and not-ready with decode fields latched. Tail increments modulo ROB_SIZE (wraps from ROB_SIZE-1 to 0).
- CDB writeback:
  - When rdy && in_cdb_valid && entry[tag].busy, store value, taken and target, and set ready.
  - A write to a non-busy tag is ignored.
- Operand query is combinational: ready = busy && ready; value = stored value.
- Commit (one per cycle max) happens when rdy && entry[head].busy && entry[head].ready. The head entry is freed and head increments. On the next edge:
  - out_commit_reg = dest_reg (forced to 0 for branches).
  - out_commit_rob = head.
  - out_commit_value = value.
- Registered commit outputs are valid for exactly one cycle. The next cycle without a commit returns all three to 0. The register file ignores reg 0.
- Misprediction:
  - Triggered when the committing head is a branch with taken != pred_taken.
  - Next cycle: out_misbranch = 1 and out_misbranch_pc = stored target, for one cycle.
  - In the commit cycle itself: head, tail and count go to 0, all entries are cleared, and any same-cycle allocation and CDB write are discarded.
- Simultaneous allocate + commit: count is unchanged. When full with a same-cycle commit, the allocation is still refused (pre-update full).
- rdy low: queue state is held. Commit and misbranch outputs are driven 0 on the next edge.
- Latency:
  - Allocate to earliest commit is 2 cycles (CDB write in the cycle after allocation).
  - Commit to register file visibility is 1 cycle.

Optional Feature:
- ROB_CDB_BYPASS_EN.
- Defined: the query returns in_cdb_value with ready=1 when in_cdb_valid and in_cdb_rob_tag matches the queried busy entry in the same cycle.
- Undefined: the query reflects stored state only, so a result becomes visible one cycle after the CDB write.

Decomposition:
- Shared constant header (constant.v) holds DATA_WIDTH, REG_TAG_WIDTH, ROB_TAG_WIDTH, ROB_SIZE, ZERO_DATA, ZERO_TAG_ROB, TRUE, FALSE. The module reuses these.
- One sub-module, rob_queue_ctrl: head/tail/count pointer logic with full flag, allocate/commit/flush inputs and wrap-around.
- Entry storage and commit logic stay in rob_commit.

Test Plan:
- Reset, allocate tag 0 with dest x5, CDB tag 0 value 0x1234 → next cycle commit_reg=5, commit_rob=0, commit_value=0x1234; the cycle after, commit_reg=0.
- Allocate 16 entries with no CDB → full=1 and a 17th ce is ignored. Then CDB tag 0 and commit, allocating in the same cycle → refused. Next cycle the allocation gets tag 0 (wrap).
- Allocate tags 0,1,2; CDB writes 2 then 1 then 0 → commits appear in order 0,1,2 on consecutive cycles.
- Branch at tag 0 pred_taken=0, CDB taken=1 target 0x100, younger tags 1-3 allocated → misbranch=1 with pc=0x100 for one cycle; no commit of 1-3; alloc_tag returns 0.
- Query tag 1 while its CDB write occurs: with ROB_CDB_BYPASS_EN, ready=1 in the same cycle; without it, ready=0 then 1 the next cycle.
- Assert rst mid-stream with 5 entries busy → immediate count=0, full=0, all outputs 0; rdy low for 3 cycles freezes the queue.
